// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters.
// Zero-latency lookup for the IF-stage PC; single-cycle training port from ID.
module branch_predictor #(
   parameter int BTB_ENTRIES = 16,
   parameter int IDX_W       = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] if_pc,
   output logic [31:0] pred_next_pc,
   output logic        pred_br_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_br,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispred,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_mispred
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic              valid_q  [BTB_ENTRIES];
   logic              valid_d  [BTB_ENTRIES];
   logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
   logic [TAG_W-1:0]  tag_d    [BTB_ENTRIES];
   logic [29:0]       target_q [BTB_ENTRIES];
   logic [29:0]       target_d [BTB_ENTRIES];
   logic [1:0]        ctr_q    [BTB_ENTRIES];
   logic [1:0]        ctr_d    [BTB_ENTRIES];
   logic [31:0]       stat_lookups_q, stat_lookups_d;
   logic [31:0]       stat_mispred_q, stat_mispred_d;

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit;
   logic [IDX_W-1:0]  up_idx;
   logic [TAG_W-1:0]  up_tag;
   logic              up_hit;
   logic              unused_low_bits;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   function automatic logic [31:0] stat_inc(input logic [31:0] s);
      return (s == 32'hffff_ffff) ? s : s + 32'd1;
   endfunction

   // Word-aligned targets: the low two address bits are never stored.
   assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

   assign lk_idx = if_pc[IDX_W+1:2];
   assign lk_tag = if_pc[31:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[31:IDX_W+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Lookup reads the registered state only, so a same-cycle update is not bypassed.
   always_comb begin
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_br_taken = lk_hit && ctr_q[lk_idx][1];
      pred_next_pc  = pred_br_taken ? {target_q[lk_idx], 2'b00} : if_pc + 32'd4;
   end

   always_comb begin
      valid_d        = valid_q;
      tag_d          = tag_q;
      target_d       = target_q;
      ctr_d          = ctr_q;
      stat_lookups_d = stat_lookups_q;
      stat_mispred_d = stat_mispred_q;
      if (upd_valid) begin
         if (!upd_is_br) begin
            // A non-branch hitting an entry means a stale alias; drop it.
            if (up_hit) valid_d[up_idx] = 1'b0;
         end else if (up_hit) begin
            if (upd_taken) begin
               ctr_d[up_idx]    = ctr_inc(ctr_q[up_idx]);
               target_d[up_idx] = upd_target[31:2];
            end else begin
               ctr_d[up_idx]    = ctr_dec(ctr_q[up_idx]);
            end
         end else if (upd_taken) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target[31:2];
            ctr_d[up_idx]    = 2'b10;
         end
         if (upd_is_br)   stat_lookups_d = stat_inc(stat_lookups_q);
         if (upd_mispred) stat_mispred_d = stat_inc(stat_mispred_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < BTB_ENTRIES; k++) begin
            valid_q[k]  <= 1'b0;
            tag_q[k]    <= '0;
            target_q[k] <= '0;
            ctr_q[k]    <= 2'b01;
         end
         stat_lookups_q <= '0;
         stat_mispred_q <= '0;
      end else begin
         valid_q        <= valid_d;
         tag_q          <= tag_d;
         target_q       <= target_d;
         ctr_q          <= ctr_d;
         stat_lookups_q <= stat_lookups_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   assign stat_lookups = stat_lookups_q;
   assign stat_mispred = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural table-of-branches model.
module tb_branch_predictor;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] if_pc;
   logic [31:0] pred_next_pc;
   logic        pred_br_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_br;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispred;
   logic [31:0] stat_lookups;
   logic [31:0] stat_mispred;

   int checks = 0;
   int errors = 0;

   // Model: one remembered branch per slot, with a confidence level 0..3.
   bit          m_valid [N];
   logic [31:0] m_pc    [N];
   logic [31:0] m_tgt   [N];
   int          m_conf  [N];
   longint      m_lk, m_mp;

   branch_predictor #(.BTB_ENTRIES(N), .IDX_W(4)) dut (
      .clk(clk), .resetn(resetn), .if_pc(if_pc),
      .pred_next_pc(pred_next_pc), .pred_br_taken(pred_br_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
      .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 32'd4) % 32'(N));
   endfunction

   function automatic bit same_region(input logic [31:0] a, input logic [31:0] b);
      return (a / 32'(4 * N)) == (b / 32'(4 * N));
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[slot(pc)] && same_region(m_pc[slot(pc)], pc);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < N; k++) begin
         m_valid[k] = 0; m_pc[k] = 0; m_tgt[k] = 0; m_conf[k] = 1;
      end
      m_lk = 0; m_mp = 0;
   endfunction

   function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] nx);
      t  = m_hit(pc) && (m_conf[slot(pc)] >= 2);
      nx = t ? m_tgt[slot(pc)] : pc + 32'd4;
   endfunction

   function automatic void model_update();
      int s;
      bit h;
      if (!upd_valid) return;
      s = slot(upd_pc);
      h = m_hit(upd_pc);
      if (upd_is_br && m_lk < 64'hffff_ffff) m_lk++;
      if (upd_mispred && m_mp < 64'hffff_ffff) m_mp++;
      if (!upd_is_br) begin
         if (h) m_valid[s] = 0;
      end else if (h) begin
         if (upd_taken) begin
            if (m_conf[s] < 3) m_conf[s]++;
            m_tgt[s] = upd_target & ~32'd3;
         end else if (m_conf[s] > 0) m_conf[s]--;
      end else if (upd_taken) begin
         m_valid[s] = 1; m_pc[s] = upd_pc; m_tgt[s] = upd_target & ~32'd3; m_conf[s] = 2;
      end
   endfunction

   task automatic drive(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                        input bit br, input bit tk, input logic [31:0] tgt, input bit mp);
      @(negedge clk);
      if_pc = pc; upd_valid = uv; upd_pc = upc; upd_is_br = br;
      upd_taken = tk; upd_target = tgt; upd_mispred = mp;
      #1;
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
      model_update();
      upd_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      if_pc = 32'h1c00_0000; upd_valid = 0; upd_pc = 0; upd_is_br = 0;
      upd_taken = 0; upd_target = 0; upd_mispred = 0;
      model_reset();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_br_taken); end
      checks++; if (pred_next_pc !== 32'h1c00_0004) begin errors++; $display("FAIL reset_next_pc: got %h want 1c000004", pred_next_pc); end
      checks++; if (stat_lookups !== 32'd0) begin errors++; $display("FAIL reset_stat_lookups: got %0d want 0", stat_lookups); end
      checks++; if (stat_mispred !== 32'd0) begin errors++; $display("FAIL reset_stat_mispred: got %0d want 0", stat_mispred); end
   endtask

   task automatic test_allocate();
      drive(32'h1c00_0000, 1, 32'h1c00_0010, 1, 1, 32'h1c00_0100, 0);
      clk_edge();
      drive(32'h1c00_0010, 0, 0, 0, 0, 0, 0);
      checks++; if (pred_br_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken: got %b want 1", pred_br_taken); end
      checks++; if (pred_next_pc !== 32'h1c00_0100) begin errors++; $display("FAIL alloc_next_pc: got %h want 1c000100", pred_next_pc); end
      checks++; if (stat_lookups !== 32'd1) begin errors++; $display("FAIL alloc_stat_lookups: got %0d want 1", stat_lookups); end
   endtask

   task automatic test_not_taken();
      logic [31:0] want_next [3] = '{32'h1c00_0014, 32'h1c00_0014, 32'h1c00_0014};
      for (int k = 0; k < 3; k++) begin
         drive(32'h1c00_0010, 1, 32'h1c00_0010, 1, 0, 32'h0, 1);
         clk_edge();
         checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL nt_taken[%0d]: got %b want 0", k, pred_br_taken); end
         checks++; if (pred_next_pc !== want_next[k]) begin errors++; $display("FAIL nt_next_pc[%0d]: got %h want %h", k, pred_next_pc, want_next[k]); end
      end
      // Entry must still be resident at counter 00: one taken reaches 01, not the fresh-allocation 10.
      drive(32'h1c00_0010, 1, 32'h1c00_0010, 1, 1, 32'h1c00_0180, 0);
      clk_edge();
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL nt_still_valid_taken: got %b want 0", pred_br_taken); end
      drive(32'h1c00_0010, 1, 32'h1c00_0010, 1, 1, 32'h1c00_0180, 0);
      clk_edge();
      checks++; if (pred_next_pc !== 32'h1c00_0180) begin errors++; $display("FAIL nt_retrain_next_pc: got %h want 1c000180", pred_next_pc); end
      checks++; if (stat_mispred !== 32'd3) begin errors++; $display("FAIL nt_stat_mispred: got %0d want 3", stat_mispred); end
      checks++; if (stat_lookups !== 32'd6) begin errors++; $display("FAIL nt_stat_lookups: got %0d want 6", stat_lookups); end
   endtask

   task automatic test_alias();
      drive(32'h1c00_0000, 1, 32'h1c00_0050, 1, 1, 32'h1c00_0200, 0);
      clk_edge();
      drive(32'h1c00_0010, 0, 0, 0, 0, 0, 0);
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL alias_old_taken: got %b want 0", pred_br_taken); end
      checks++; if (pred_next_pc !== 32'h1c00_0014) begin errors++; $display("FAIL alias_old_next_pc: got %h want 1c000014", pred_next_pc); end
      drive(32'h1c00_0050, 0, 0, 0, 0, 0, 0);
      checks++; if (pred_next_pc !== 32'h1c00_0200) begin errors++; $display("FAIL alias_new_next_pc: got %h want 1c000200", pred_next_pc); end
   endtask

   task automatic test_same_cycle();
      drive(32'h1c00_0020, 1, 32'h1c00_0020, 1, 1, 32'h1c00_0400, 0);
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old_taken: got %b want 0", pred_br_taken); end
      checks++; if (pred_next_pc !== 32'h1c00_0024) begin errors++; $display("FAIL same_cycle_old_next_pc: got %h want 1c000024", pred_next_pc); end
      clk_edge();
      checks++; if (pred_next_pc !== 32'h1c00_0400) begin errors++; $display("FAIL same_cycle_new_next_pc: got %h want 1c000400", pred_next_pc); end
      drive(32'h1c00_0020, 1, 32'h1c00_0020, 0, 0, 32'h0, 0);
      checks++; if (pred_br_taken !== 1'b1) begin errors++; $display("FAIL invalidate_pre_taken: got %b want 1", pred_br_taken); end
      clk_edge();
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL invalidate_taken: got %b want 0", pred_br_taken); end
      checks++; if (pred_next_pc !== 32'h1c00_0024) begin errors++; $display("FAIL invalidate_next_pc: got %h want 1c000024", pred_next_pc); end
   endtask

   task automatic test_random();
      bit          et;
      logic [31:0] en, lpc, upc, base;
      for (int k = 0; k < 400; k++) begin
         base = ($urandom_range(0, 7) == 0) ? 32'hffff_ff00 : 32'h1c00_0000;
         lpc  = base + 32'($urandom_range(0, 63)) * 4;
         upc  = ($urandom_range(0, 2) == 0) ? lpc : base + 32'($urandom_range(0, 63)) * 4;
         drive(lpc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0);
         model_predict(lpc, et, en);
         checks++; if (pred_br_taken !== et) begin errors++; $display("FAIL rand_taken[%0d]: pc %h got %b want %b", k, lpc, pred_br_taken, et); end
         checks++; if (pred_next_pc !== en) begin errors++; $display("FAIL rand_next_pc[%0d]: pc %h got %h want %h", k, lpc, pred_next_pc, en); end
         clk_edge();
         checks++; if (stat_lookups !== m_lk[31:0]) begin errors++; $display("FAIL rand_stat_lookups[%0d]: got %0d want %0d", k, stat_lookups, m_lk); end
         checks++; if (stat_mispred !== m_mp[31:0]) begin errors++; $display("FAIL rand_stat_mispred[%0d]: got %0d want %0d", k, stat_mispred, m_mp); end
      end
   endtask

   task automatic test_reset_mid_update();
      logic [31:0] pcs [4] = '{32'h1c00_0030, 32'h1c00_0034, 32'h1c00_0038, 32'h1c00_003c};
      for (int k = 0; k < 3; k++) begin
         drive(32'h1c00_0000, 1, pcs[k], 1, 1, 32'h1c00_0800 + 32'(k) * 16, 1);
         clk_edge();
      end
      drive(pcs[1], 1, pcs[3], 1, 1, 32'h1c00_0900, 1);
      checks++; if (pred_next_pc !== 32'h1c00_0810) begin errors++; $display("FAIL prereset_hit: got %h want 1c000810", pred_next_pc); end
      #2 resetn = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         if_pc = pcs[k];
         #1;
         checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL inreset_taken[%0d]: got %b want 0", k, pred_br_taken); end
         checks++; if (pred_next_pc !== pcs[k] + 32'd4) begin errors++; $display("FAIL inreset_next_pc[%0d]: got %h want %h", k, pred_next_pc, pcs[k] + 32'd4); end
      end
      checks++; if (stat_lookups !== 32'd0) begin errors++; $display("FAIL inreset_stat_lookups: got %0d want 0", stat_lookups); end
      checks++; if (stat_mispred !== 32'd0) begin errors++; $display("FAIL inreset_stat_mispred: got %0d want 0", stat_mispred); end
      if_pc = 32'hffff_fffc;
      #1;
      checks++; if (pred_next_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next_pc: got %h want 00000000", pred_next_pc); end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      if_pc = pcs[3];
      #1;
      checks++; if (pred_br_taken !== 1'b0) begin errors++; $display("FAIL discarded_update_taken: got %b want 0", pred_br_taken); end
      checks++; if (stat_lookups !== 32'd0) begin errors++; $display("FAIL postreset_stat_lookups: got %0d want 0", stat_lookups); end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_not_taken();
      test_alias();
      test_same_cycle();
      test_random();
      test_reset_mid_update();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
